fb_write_arbiter: RTL and testbench
===================================

# fb_write_arbiter

Write-side scheduler for the 640x480 8-bit colour-index frame buffer scanned out by the VGA controller. It shares the single RAM write port among the two player trail writers (port 0, port 1) and a full-screen clear engine. Requests are arbitrated round-robin. A clear, once requested, waits for the start of vertical sync and then owns the write port until every pixel is rewritten. It sits between game logic and the write port of the frame-buffer RAM, clocked by the pixel clock.

## Interface
- ADDR_W, 19, frame-buffer address width
- DATA_W, 8, colour-index width
- NPIX, 307200, number of pixels (valid addresses 0..NPIX-1)

- iVGA_CLK  in  1  pixel clock; single clock domain, all logic on rising edge
- iRST_n  in  1  asynchronous, active-low reset
- iVS  in  1  active-low vertical sync from the sync generator, synchronous to iVGA_CLK
- iReq0 / iReq1  in  1  write request, player port 0 / 1
- iAddr0 / iAddr1  in  ADDR_W  pixel address for port 0 / 1
- iData0 / iData1  in  DATA_W  colour index for port 0 / 1
- oAck0 / oAck1  out  1  one-cycle grant pulse, port 0 / 1
- iClear  in  1  clear request pulse
- iClearColor  in  DATA_W  fill value, sampled with iClear
- oClearBusy  out  1  clear pending or in progress
- oRangeErr  out  1  sticky: an out-of-range address was acked
- oWE  out  1  RAM write enable
- oWADDR  out  ADDR_W  RAM write address
- oWDATA  out  DATA_W  RAM write data

## Operation
- FSM states:
  - IDLE: players arbitrated.
  - ARM: clear latched, waiting for vsync; players still arbitrated.
  - CLEAR: walk all pixels; players blocked.
- IDLE -> ARM: on a cycle with iClear=1. The block latches iClearColor, and oClearBusy goes to 1 on the next edge.
- ARM -> CLEAR: on a detected falling edge of iVS (registered previous iVS = 1, current iVS = 0).
- CLEAR -> IDLE: after the write to address NPIX-1 is issued.
- iClear is ignored in ARM and CLEAR, with no queueing.
- Clear counter is ADDR_W bits and starts at 0. In CLEAR, each cycle issues oWE=1, oWADDR=counter, oWDATA=latched colour, then increments the counter. The counter stops at NPIX-1 and never wraps.
- Player arbitration (IDLE, ARM):
  - A port is eligible when its iReq=1 and its oAck is currently 0. A port is therefore granted at most every other cycle.
  - One eligible port: that port is granted.
  - Both eligible: grant the port not granted last. The last-grant pointer resets to 1, so port 0 wins the first tie.
- Grant effects (registered on the next edge):
  - oAck of the winner pulses for one cycle.
  - oWADDR/oWDATA take that port's sampled address and data.
  - oWE=1 only if address < NPIX. Otherwise oWE=0, the request is still acked, and oRangeErr is set.
- Requesters must hold iReq, iAddr and iData stable until they see oAck=1. They may change them in the ack cycle.
- If no grant and not CLEAR, oWE=0. oWADDR and oWDATA hold their last value.
- oRangeErr clears on reset and on ARM -> CLEAR.
- In CLEAR, player requests are ignored: no ack, and they wait.
- If iVS falls in the same cycle a player port is eligible during ARM, the state enters CLEAR and the player is not granted.

## Timing
- Reset values: state IDLE, oAck0=oAck1=0, oWE=0, oWADDR=0, oWDATA=0, oClearBusy=0, oRangeErr=0, counter=0, last-grant=1, previous iVS=1.
- Player write latency: request sampled at edge N; oAck and the write appear together after edge N.
- Sustained throughput is one write per cycle with both ports requesting, alternating 0,1,0,1. A single port alone gets one write per 2 cycles.
- Clear latency: the first clear write (address 0) is driven in the cycle after the edge that detects the iVS fall. Writes are issued on NPIX consecutive cycles.
- Clear end: oClearBusy drops at the edge where the state returns to IDLE, i.e. the cycle after the address-NPIX-1 write. Players can be acked from that same edge.
- Reset asserted mid-clear or mid-handshake forces reset values asynchronously. The partial clear is abandoned and not resumed.

## Test plan
- Port 0 only: iReq0=1, iAddr0=100, iData0=8'h2A held -> oAck0 and oWE=1, oWADDR=100, oWDATA=8'h2A one cycle later; grants every 2 cycles while held.
- Both ports requesting continuously from reset: grants alternate starting with port 0 (0,1,0,1), and oWE=1 every cycle.
- iAddr1=307200 -> oAck1 pulses, oWE=0, and oRangeErr=1 and stays set until the next clear starts.
- iClear with iClearColor=8'h05 while iVS=1 -> oClearBusy=1 and players are still granted. iVS then falls -> 307200 consecutive writes of 8'h05 to addresses 0..307199, and no oAck during that time. oClearBusy=0 the cycle after the last write.
- Second iClear pulse during CLEAR -> ignored, with exactly one 307200-write pass.
- Assert iRST_n=0 at clear address 1000 -> all outputs at reset values immediately. After release, the state is IDLE and no clear writes occur.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port scheduler: round-robin between two player trail writers,
// plus a vsync-aligned full-screen clear that owns the port until every pixel is rewritten.
module fb_write_arbiter #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 8,
   parameter int NPIX   = 307200
) (
   input  logic              iVGA_CLK,
   input  logic              iRST_n,
   input  logic              iVS,
   input  logic              iReq0,
   input  logic [ADDR_W-1:0] iAddr0,
   input  logic [DATA_W-1:0] iData0,
   input  logic              iReq1,
   input  logic [ADDR_W-1:0] iAddr1,
   input  logic [DATA_W-1:0] iData1,
   output logic              oAck0,
   output logic              oAck1,
   input  logic              iClear,
   input  logic [DATA_W-1:0] iClearColor,
   output logic              oClearBusy,
   output logic              oRangeErr,
   output logic              oWE,
   output logic [ADDR_W-1:0] oWADDR,
   output logic [DATA_W-1:0] oWDATA
);

   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
   localparam logic [ADDR_W:0]   PIX_LIM  = (ADDR_W + 1)'(NPIX);

   typedef enum logic [1:0] {IDLE, ARM, CLEAR} state_t;

   state_t              r_state;
   logic                r_vsPrev;
   logic                r_lastGrant;
   logic [ADDR_W-1:0]   r_cnt;
   logic [DATA_W-1:0]   r_color;

   logic                w_vsFall;
   logic                w_elig0;
   logic                w_elig1;
   logic                w_canArb;
   logic                w_grant0;
   logic                w_grant1;
   logic [ADDR_W-1:0]   w_selAddr;
   logic [DATA_W-1:0]   w_selData;
   logic                w_inRange;

   // A port just acked is ineligible for one cycle; arbitration also runs on the clear's final edge.
   always_comb begin
      w_vsFall  = r_vsPrev & ~iVS;
      w_elig0   = iReq0 & ~oAck0;
      w_elig1   = iReq1 & ~oAck1;
      w_canArb  = (r_state == IDLE) ||
                  ((r_state == ARM) && !w_vsFall) ||
                  ((r_state == CLEAR) && (r_cnt == LAST_PIX));
      w_grant0  = w_canArb & w_elig0 & (~w_elig1 | r_lastGrant);
      w_grant1  = w_canArb & w_elig1 & (~w_elig0 | ~r_lastGrant);
      w_selAddr = w_grant1 ? iAddr1 : iAddr0;
      w_selData = w_grant1 ? iData1 : iData0;
      w_inRange = {1'b0, w_selAddr} < PIX_LIM;
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_state     <= IDLE;
         r_vsPrev    <= 1'b1;
         r_lastGrant <= 1'b1;
         r_cnt       <= '0;
         r_color     <= '0;
         oAck0       <= 1'b0;
         oAck1       <= 1'b0;
         oClearBusy  <= 1'b0;
         oRangeErr   <= 1'b0;
         oWE         <= 1'b0;
         oWADDR      <= '0;
         oWDATA      <= '0;
      end else begin
         r_vsPrev <= iVS;
         oAck0    <= w_grant0;
         oAck1    <= w_grant1;
         oWE      <= 1'b0;

         if (w_grant0 || w_grant1) begin
            oWADDR      <= w_selAddr;
            oWDATA      <= w_selData;
            oWE         <= w_inRange;
            r_lastGrant <= w_grant1;
            if (!w_inRange) begin
               oRangeErr <= 1'b1;
            end
         end

         // The counter always holds the address currently on the write port during CLEAR.
         case (r_state)
            IDLE: begin
               if (iClear) begin
                  r_state    <= ARM;
                  r_color    <= iClearColor;
                  oClearBusy <= 1'b1;
               end
            end
            ARM: begin
               if (w_vsFall) begin
                  r_state   <= CLEAR;
                  r_cnt     <= '0;
                  oWE       <= 1'b1;
                  oWADDR    <= '0;
                  oWDATA    <= r_color;
                  oRangeErr <= 1'b0;
               end
            end
            CLEAR: begin
               if (r_cnt == LAST_PIX) begin
                  r_state    <= IDLE;
                  oClearBusy <= 1'b0;
               end else begin
                  r_cnt  <= r_cnt + 1'b1;
                  oWE    <= 1'b1;
                  oWADDR <= r_cnt + 1'b1;
                  oWDATA <= r_color;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized bench for fb_write_arbiter against a cycle-level reference model of the scheduling rules.
// A small pixel count keeps each clear pass short.
module tb_fb_write_arbiter;

   localparam int ADDR_W = 19;
   localparam int DATA_W = 8;
   localparam int NPIX   = 64;

   logic              clk = 1'b0;
   logic              rstN;
   logic              iVS;
   logic              iReq0, iReq1;
   logic [ADDR_W-1:0] iAddr0, iAddr1;
   logic [DATA_W-1:0] iData0, iData1;
   logic              oAck0, oAck1;
   logic              iClear;
   logic [DATA_W-1:0] iClearColor;
   logic              oClearBusy, oRangeErr, oWE;
   logic [ADDR_W-1:0] oWADDR;
   logic [DATA_W-1:0] oWDATA;

   fb_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NPIX(NPIX)) dut (
      .iVGA_CLK(clk), .iRST_n(rstN), .iVS(iVS),
      .iReq0(iReq0), .iAddr0(iAddr0), .iData0(iData0),
      .iReq1(iReq1), .iAddr1(iAddr1), .iData1(iData1),
      .oAck0(oAck0), .oAck1(oAck1),
      .iClear(iClear), .iClearColor(iClearColor),
      .oClearBusy(oClearBusy), .oRangeErr(oRangeErr),
      .oWE(oWE), .oWADDR(oWADDR), .oWDATA(oWDATA)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: mode 0 = idle, 1 = clear armed, 2 = clearing
   int mMode, mNext, mLast, mVsPrev, mColor;
   int eAck0, eAck1, eWe, eAddr, eData, eBusy, eErr;
   int passWrites, passes;

   // Stimulus controls
   int gP0, gP1, gPClr, gPOor, gVsOn, gFixed0, gOor1;
   int pend0, pend1, vsCnt;
   logic [31:0] a0, a1, d0, d1;

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mMode = 0; mNext = 0; mLast = 1; mVsPrev = 1; mColor = 0;
      eAck0 = 0; eAck1 = 0; eWe = 0; eAddr = 0; eData = 0; eBusy = 0; eErr = 0;
      passWrites = 0;
   endtask

   task automatic checkAll();
      checkOutput("oAck0", oAck0, eAck0);
      checkOutput("oAck1", oAck1, eAck1);
      checkOutput("oWE", oWE, eWe);
      checkOutput("oWADDR", oWADDR, eAddr);
      checkOutput("oWDATA", oWDATA, eData);
      checkOutput("oClearBusy", oClearBusy, eBusy);
      checkOutput("oRangeErr", oRangeErr, eErr);
   endtask

   task automatic applyStimulus();
      if (eAck0 != 0) pend0 = 0;
      if (eAck1 != 0) pend1 = 0;
      if (pend0 == 0 && $urandom_range(99) < gP0) begin
         pend0 = 1;
         a0 = ($urandom_range(99) < gPOor) ? NPIX + $urandom_range(40) : $urandom_range(NPIX - 1);
         d0 = $urandom_range(255);
         if (gFixed0 != 0) begin a0 = 100; d0 = 8'h2A; end
      end
      if (pend1 == 0 && $urandom_range(99) < gP1) begin
         pend1 = 1;
         a1 = ($urandom_range(99) < gPOor) ? NPIX + $urandom_range(40) : $urandom_range(NPIX - 1);
         d1 = $urandom_range(255);
         if (gOor1 != 0) a1 = NPIX;
      end
      iReq0 = pend0[0]; iAddr0 = a0[ADDR_W-1:0]; iData0 = d0[DATA_W-1:0];
      iReq1 = pend1[0]; iAddr1 = a1[ADDR_W-1:0]; iData1 = d1[DATA_W-1:0];
      iClear = ($urandom_range(999) < gPClr);
      iClearColor = DATA_W'($urandom_range(255));
      vsCnt++;
      iVS = (gVsOn != 0) ? ((vsCnt % 150) >= 3) : 1'b1;
   endtask

   // Predicts the outputs after the coming rising edge from the current inputs.
   task automatic modelStep();
      int vsFall, el0, el1, arb, g;
      vsFall = (mVsPrev == 1 && iVS == 1'b0) ? 1 : 0;
      el0 = (iReq0 && eAck0 == 0) ? 1 : 0;
      el1 = (iReq1 && eAck1 == 0) ? 1 : 0;
      arb = (mMode == 0) || (mMode == 1 && vsFall == 0) || (mMode == 2 && mNext == NPIX - 1);
      g = -1;
      if (arb != 0) begin
         if (el0 != 0 && el1 != 0) g = 1 - mLast;
         else if (el0 != 0) g = 0;
         else if (el1 != 0) g = 1;
      end
      eAck0 = (g == 0); eAck1 = (g == 1); eWe = 0;
      if (g >= 0) begin
         eAddr = (g == 0) ? int'(iAddr0) : int'(iAddr1);
         eData = (g == 0) ? int'(iData0) : int'(iData1);
         if (eAddr < NPIX) eWe = 1; else eErr = 1;
         mLast = g;
      end
      if (mMode == 0) begin
         if (iClear) begin mMode = 1; mColor = iClearColor; eBusy = 1; end
      end else if (mMode == 1) begin
         if (vsFall != 0) begin
            mMode = 2; mNext = 0; eWe = 1; eAddr = 0; eData = mColor; eErr = 0;
         end
      end else begin
         if (mNext == NPIX - 1) begin
            mMode = 0; eBusy = 0;
            checkOutput("clearPassWrites", passWrites, NPIX);
            passWrites = 0;
            passes++;
         end else begin
            mNext++; eWe = 1; eAddr = mNext; eData = mColor;
         end
      end
      mVsPrev = iVS;
   endtask

   task automatic runCycle();
      @(negedge clk);
      checkAll();
      if (mMode == 2 && oWE) passWrites++;
      applyStimulus();
      modelStep();
   endtask

   task automatic setMode(input int p0, input int p1, input int pClr, input int pOor,
                          input int vsOn, input int fixed0, input int oor1);
      gP0 = p0; gP1 = p1; gPClr = pClr; gPOor = pOor; gVsOn = vsOn; gFixed0 = fixed0; gOor1 = oor1;
   endtask

   task automatic releaseReset();
      @(negedge clk);
      rstN = 1'b1;
      checkAll();
      applyStimulus();
      modelStep();
   endtask

   initial begin
      int budget;
      rstN = 1'b0; iVS = 1'b1; iReq0 = 0; iReq1 = 0; iAddr0 = '0; iAddr1 = '0;
      iData0 = '0; iData1 = '0; iClear = 0; iClearColor = '0;
      pend0 = 0; pend1 = 0; vsCnt = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0; passes = 0;
      modelReset();
      repeat (3) @(posedge clk);

      // Both ports from reset: port 0 wins the first tie, then strict alternation.
      setMode(100, 100, 0, 0, 0, 0, 0);
      releaseReset();
      repeat (30) runCycle();

      // Port 0 alone with a fixed pixel: one grant every other cycle.
      setMode(100, 0, 0, 0, 0, 1, 0);
      repeat (12) runCycle();

      // Port 1 at the first out-of-range address: acked, no write, sticky error.
      setMode(0, 100, 0, 0, 0, 0, 1);
      repeat (8) runCycle();
      setMode(40, 40, 0, 0, 0, 0, 0);
      repeat (10) runCycle();

      // Mixed traffic with clears and vsync, including clear pulses while busy.
      setMode(60, 60, 20, 10, 1, 0, 0);
      repeat (1500) runCycle();

      // Reset in the middle of a clear pass.
      setMode(50, 50, 200, 5, 1, 0, 0);
      budget = 0;
      while (!(mMode == 2 && mNext == 20) && budget < 2000) begin
         runCycle();
         budget++;
      end
      checkOutput("reachClearMid", (mMode == 2 && mNext == 20), 1);
      @(negedge clk);
      checkAll();
      rstN = 1'b0;
      #1;
      checkOutput("rstAck0", oAck0, 0);
      checkOutput("rstAck1", oAck1, 0);
      checkOutput("rstWE", oWE, 0);
      checkOutput("rstWADDR", oWADDR, 0);
      checkOutput("rstWDATA", oWDATA, 0);
      checkOutput("rstBusy", oClearBusy, 0);
      checkOutput("rstErr", oRangeErr, 0);
      modelReset();
      pend0 = 0; pend1 = 0;
      iReq0 = 0; iReq1 = 0; iClear = 0;
      repeat (2) @(posedge clk);
      setMode(60, 60, 0, 5, 1, 0, 0);
      releaseReset();
      repeat (300) runCycle();

      // More mixed traffic after recovery.
      setMode(70, 50, 15, 10, 1, 0, 0);
      repeat (800) runCycle();

      checkOutput("clearPassesSeen", (passes >= 2), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
